// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction
// fetch port and a data (MEM stage) port through a three-state FSM
// (IDLE, FETCH, DATA).
//
// Handshake: each requester raises its req with stable address/data and
// holds it until its valid pulses. The memory side sees mem_req with stable
// mem_we/mem_addr/mem_wdata until mem_ready is sampled high. mem_ready
// completes the access in that same cycle. Each access takes at least
// 2 cycles, and at least one IDLE cycle separates consecutive grants.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to count consecutive
// data grants made while a fetch waits. When the count reaches
// STARVE_LIMIT, the next arbitration is forced to FETCH. Without the
// macro, data has strict priority.
//
// dbg_state exposes the FSM state (0 IDLE, 1 FETCH, 2 DATA).
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t state;
  logic   force_fetch;
  logic   grant_data;

  // Data wins arbitration unless the starvation guard forces a fetch.
  assign grant_data = dm_req && !force_fetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic [CW-1:0] starve_cnt;

  assign force_fetch = if_req && (starve_cnt == CW'(STARVE_LIMIT));

  // Count data grants made over a waiting fetch; clear on a fetch grant
  // or on any IDLE cycle where no fetch is waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (grant_data) begin
        starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign force_fetch = 1'b0;

  // STARVE_LIMIT has no effect in this build; this block only references it.
  if (STARVE_LIMIT < 0) begin : g_limit_unused
  end
`endif

  // Arbitration FSM with registered memory-side request, address and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (if_req) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end else begin
            mem_req <= 1'b0;
          end
        end
        FETCH, DATA: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Completion is combinational on mem_ready; masked while reset is high so
  // an abandoned access never reports completion.
  assign if_valid  = !reset && (state == FETCH) && mem_ready;
  assign dm_valid  = !reset && (state == DATA) && mem_ready;
  assign if_stall  = if_req && !if_valid;
  assign dm_stall  = dm_req && !dm_valid;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign dbg_state = state;

endmodule
